// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and write-back source ids
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } src_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - issue, write-back and register-file port bundle (WB_FORWARD_EN adds forwarding outputs)
interface regfile_wb_scheduler_if;
  import regfile_pkg::*;

  logic            issue_valid;
  logic [AW-1:0]   issue_rs1;
  logic [AW-1:0]   issue_rs2;
  logic [AW-1:0]   issue_rd;
  logic            issue_wr;
  logic            stall;

  logic            s0_valid;
  logic [AW-1:0]   s0_rd;
  logic [XLEN-1:0] s0_data;
  logic            s0_ready;
  logic            s1_valid;
  logic [AW-1:0]   s1_rd;
  logic [XLEN-1:0] s1_data;
  logic            s1_ready;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            err;

`ifdef WB_FORWARD_EN
  logic            fwd1_en;
  logic            fwd2_en;
  logic [XLEN-1:0] fwd1_data;
  logic [XLEN-1:0] fwd2_data;
`endif

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
    output s0_valid, s0_rd, s0_data, s1_valid, s1_rd, s1_data,
    input  stall, s0_ready, s1_ready, wr_en, wr_addr, wr_data, err
`ifdef WB_FORWARD_EN
    , input fwd1_en, fwd2_en, fwd1_data, fwd2_data
`endif
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
    input  s0_valid, s0_rd, s0_data, s1_valid, s1_rd, s1_data,
    output stall, s0_ready, s1_ready, wr_en, wr_addr, wr_data, err
`ifdef WB_FORWARD_EN
    , output fwd1_en, fwd2_en, fwd1_data, fwd2_data
`endif
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter; last_grant resets to SRC_LOAD so s0 wins first
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  src_t last_grant;

  always_comb begin
    gnt0 = req0 && (!req1 || (last_grant == SRC_LOAD));
    gnt1 = req1 && !gnt0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= SRC_LOAD;
    end else if (gnt0) begin
      last_grant <= SRC_ALU;
    end else if (gnt1) begin
      last_grant <= SRC_LOAD;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - write-back arbiter, busy scoreboard and hazard stall; WB_FORWARD_EN enables operand forwarding
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  regfile_wb_scheduler_if.slave bus
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_clr;
  logic [NREGS-1:0] busy_nxt;
  logic             gnt0;
  logic             gnt1;
  logic [AW-1:0]    sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             wb_fire;
  logic             wb_orphan;
  logic             hit1;
  logic             hit2;
  logic             issue_set;
  logic             stall_i;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (bus.s0_valid),
    .req1    (bus.s1_valid),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign bus.s0_ready = gnt0;
  assign bus.s1_ready = gnt1;

`ifdef WB_FORWARD_EN
  assign hit1 = bus.wr_en && (bus.wr_addr == bus.issue_rs1) && (bus.wr_addr != '0);
  assign hit2 = bus.wr_en && (bus.wr_addr == bus.issue_rs2) && (bus.wr_addr != '0);
  assign bus.fwd1_en   = hit1;
  assign bus.fwd2_en   = hit2;
  assign bus.fwd1_data = bus.wr_data;
  assign bus.fwd2_data = bus.wr_data;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // WAW is never forwarded: the older write must land before the new owner claims rd
  assign stall_i = bus.issue_valid &&
                   ((busy[bus.issue_rs1] && !hit1) ||
                    (busy[bus.issue_rs2] && !hit2) ||
                    (bus.issue_wr && busy[bus.issue_rd]));
  assign bus.stall = stall_i;

  always_comb begin
    sel_rd    = gnt1 ? bus.s1_rd : bus.s0_rd;
    sel_data  = gnt1 ? bus.s1_data : bus.s0_data;
    wb_fire   = (gnt0 || gnt1) && (sel_rd != '0);
    issue_set = bus.issue_valid && !stall_i && bus.issue_wr && (bus.issue_rd != '0);

    busy_clr = '0;
    if (bus.wr_en) begin
      busy_clr[bus.wr_addr] = 1'b1;
    end

    // a register being retired this cycle is no longer owned by an in-flight write
    wb_orphan = wb_fire && !(busy[sel_rd] && !busy_clr[sel_rd]);

    busy_nxt = busy & ~busy_clr;
    if (issue_set) begin
      busy_nxt[bus.issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy        <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.err     <= 1'b0;
    end else begin
      busy      <= busy_nxt;
      bus.wr_en <= wb_fire;
      if (wb_fire) begin
        bus.wr_addr <= sel_rd;
        bus.wr_data <= sel_data;
      end
      if (wb_orphan) begin
        bus.err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32×32 register file. Arbitrates two write-back sources (ALU and load unit) onto the register file's single write port and keeps a per-register busy scoreboard. The scoreboard drives a hazard stall to the issue stage. It sits between the execute/memory units and the register file write port (`write_enable`/`write_reg`/`write_data`).

## Interface
- XLEN, 32: data width.
- NREGS, 32: register count. AW = log2(NREGS) = 5.

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- issue_valid  in  1  issue stage presents an instruction.
- issue_rs1, issue_rs2, issue_rd  in  AW each  source and destination registers of the presented instruction.
- issue_wr  in  1  instruction writes issue_rd.
- stall  out  1  combinational hazard: issue must hold.
- s0_valid, s1_valid  in  1 each  ALU (s0) / load (s1) write-back request.
- s0_rd, s1_rd  in  AW each  destination register.
- s0_data, s1_data  in  XLEN each  write-back data.
- s0_ready, s1_ready  out  1 each  combinational grant; transfer occurs on valid && ready.
- wr_en  out  1  to register file write_enable.
- wr_addr  out  AW  to register file write_reg.
- wr_data  out  XLEN  to register file write_data.
- err  out  1  sticky: write-back arrived for a non-busy register.

## Operation
- Issue is accepted when issue_valid && !stall.
- On acceptance with issue_wr && issue_rd != 0: busy[issue_rd] is set.
- stall = issue_valid && (busy[rs1] || busy[rs2] || (issue_wr && busy[rd])). This covers RAW and WAW.
- busy[0] is hard-wired to 0. Register 0 never stalls.
- Arbitration:
  - Exactly one grant per cycle when any source is valid. The write port is free every cycle, so there is no backpressure beyond arbitration.
  - Single valid source: that source is granted.
  - Both valid: round-robin. The grant goes to the source opposite last_grant.
  - last_grant updates on every grant.
- A granted request with rd != 0 is registered: wr_en=1, wr_addr=rd, wr_data=data in the next cycle. Otherwise wr_en=0.
- A granted request with rd == 0 is consumed silently: no wr_en, no scoreboard change, no err.
- busy[wr_addr] clears at the end of every cycle in which wr_en=1. This is the same edge at which the register file writes.
- A write-back to a register whose busy bit is 0 is still written. err is set and stays set until reset.
- Simultaneous issue-set and write-back-clear cannot target the same register: issue of a busy rd stalls. Set and clear on different registers in the same cycle both take effect.
- Reset clears busy to all 0, wr_en/wr_addr/wr_data to 0, err to 0, and last_grant to 1 (s0 wins the first contention).
- Reset mid-operation drops a registered pending write. wr_en is 0 in the cycle after the reset edge.

## Timing
- Grant is in cycle N. wr_en is high in N+1. The register file holds the data and busy clears at the end of N+1.
- Without forwarding, a dependent instruction stalled on that register issues in N+2.
- ready is combinational from valid and last_grant, with no internal state bubble. Sustained throughput is 1 write per cycle.
- stall is combinational from issue_* and busy. There is no issue-to-stall register.

## Configuration
- WB_FORWARD_EN defined:
  - Adds outputs fwd1_en, fwd2_en (1 bit each) and fwd1_data, fwd2_data (XLEN each).
  - If wr_en && wr_addr == rs1 and wr_addr != 0: the busy[rs1] term is suppressed in stall, fwd1_en=1 and fwd1_data=wr_data. rs2 is handled the same way.
  - The WAW term is not forwarded.
  - A dependent instruction can issue in N+1.
- Undefined: no forwarding ports, stall as above.

## Structure
- Shared package regfile_pkg holds:
  - constants XLEN=32, NREGS=32, AW=5;
  - source-id encoding SRC_ALU=0, SRC_LOAD=1.
  The register file uses the same package.
- Sub-module rr_arbiter2: 2-way round-robin arbiter with the last_grant register, reset value 1.
- The scoreboard and output register live in the top.

## Test plan
- Reset, then issue rd=5 with s0 idle → busy[5]=1. Issue with rs1=5 → stall=1. s0 writes rd=5, data 0xDEADBEEF in cycle N → wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in N+1. stall=0 in N+2, or in N+1 with forwarding and fwd1_data=0xDEADBEEF.
- Both sources valid for 4 cycles after reset → grant order s0, s1, s0, s1; wr_addr follows the same order.
- s1 writes rd=0 → wr_en stays 0, busy unchanged, err=0.
- s0 writes rd=7 with busy[7]=0 → wr_en=1 in the next cycle, err=1, and err stays 1 until reset_n=0.
- Issue rd=3 while busy[3]=1 (WAW) → stall=1 in both configurations.
- reset_n=0 in the cycle after a grant → wr_en=0 next cycle, all busy=0, err=0.
